// File: rtl/bus_pkg.sv
// Shared definitions for the register-bus master: FSM state encoding,
// bus direction codes and bus widths.
package bus_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_master.sv
// Single-outstanding bus master: turns one request into a SETUP/STROBE/HOLD
// cycle on a strobed shared bus, each phase lasting CLK_DIV system clocks.
module bus_master
  import bus_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [BUS_ADDR_W-1:0] ReqAddress,
  input  logic [BUS_DATA_W-1:0] ReqData,
  output logic                  RspValid,
  output logic [BUS_DATA_W-1:0] RspData,
  output logic [BUS_ADDR_W-1:0] BusAddress,
  inout  wire  [BUS_DATA_W-1:0] BusData,
  output logic                  BusReadWrite,
  output logic                  BusClock
);

  localparam logic [7:0] PHASE_RELOAD = 8'(CLK_DIV - 1);

  bus_state_e            state_r;
  logic [7:0]            phase_r;
  logic [BUS_DATA_W-1:0] wdata_r;
  logic                  drive_r;

  // Write data leaves the master only while a write owns the bus.
  assign BusData = drive_r ? wdata_r : {BUS_DATA_W{1'bz}};

  // Transaction FSM with phase counter; every bus-facing output is a flop.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r      <= ST_IDLE;
      phase_r      <= 8'd0;
      wdata_r      <= {BUS_DATA_W{1'b0}};
      drive_r      <= 1'b0;
      BusAddress   <= {BUS_ADDR_W{1'b0}};
      BusReadWrite <= BUS_WRITE;
      BusClock     <= 1'b0;
      ReqReady     <= 1'b0;
      RspValid     <= 1'b0;
      RspData      <= {BUS_DATA_W{1'b0}};
    end else begin
      RspValid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          ReqReady <= 1'b1;
          if (ReqValid && ReqReady) begin
            state_r      <= ST_SETUP;
            phase_r      <= PHASE_RELOAD;
            BusAddress   <= ReqAddress;
            BusReadWrite <= ReqWrite;
            wdata_r      <= ReqData;
            drive_r      <= (ReqWrite == BUS_WRITE);
            ReqReady     <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (phase_r == 8'd0) begin
            state_r  <= ST_STROBE;
            phase_r  <= PHASE_RELOAD;
            BusClock <= 1'b1;
          end else begin
            phase_r <= phase_r - 8'd1;
          end
        end
        ST_STROBE: begin
          if (phase_r == 8'd0) begin
            state_r  <= ST_HOLD;
            phase_r  <= PHASE_RELOAD;
            BusClock <= 1'b0;
          end else begin
            phase_r <= phase_r - 8'd1;
          end
        end
        ST_HOLD: begin
          if (phase_r == 8'd0) begin
            // Read data is taken while the slave is still addressed and driving.
            if (BusReadWrite == BUS_READ) begin
              RspData <= BusData;
            end
            state_r      <= ST_IDLE;
            RspValid     <= 1'b1;
            ReqReady     <= 1'b1;
            BusReadWrite <= BUS_WRITE;
            drive_r      <= 1'b0;
          end else begin
            phase_r <= phase_r - 8'd1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          BusClock     <= 1'b0;
          BusReadWrite <= BUS_WRITE;
          drive_r      <= 1'b0;
          ReqReady     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Self-checking bench: table-driven transactions and corner sequences on a
// CLK_DIV=2 master, plus randomized traffic on a CLK_DIV=1 master vs. a model.
`timescale 1ns/1ps
module tb_bus_master;

  localparam int DA = 2;
  localparam int DB = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- instance A (CLK_DIV = 2) ----------------
  logic        a_req_valid, a_req_write, a_req_ready, a_rsp_valid, a_bus_rw, a_bus_clk;
  logic [15:0] a_req_addr, a_bus_addr;
  logic [7:0]  a_req_data, a_rsp_data;
  tri1  [7:0]  a_bus_data;

  bus_master #(.CLK_DIV(DA)) dut_a (
    .Clock(clk), .Reset(rst_n), .ReqValid(a_req_valid), .ReqReady(a_req_ready),
    .ReqWrite(a_req_write), .ReqAddress(a_req_addr), .ReqData(a_req_data),
    .RspValid(a_rsp_valid), .RspData(a_rsp_data), .BusAddress(a_bus_addr),
    .BusData(a_bus_data), .BusReadWrite(a_bus_rw), .BusClock(a_bus_clk)
  );

  // Slave A: unwritten registers read as 0xA5; drives only when BusReadWrite=0.
  bit [7:0] a_mem [65536];
  bit       a_wr  [65536];
  int       a_rises = 0;
  int       a_rsps  = 0;
  assign a_bus_data = a_bus_rw ? 8'bz : (a_wr[a_bus_addr] ? a_mem[a_bus_addr] : 8'hA5);
  always @(posedge a_bus_clk) begin
    a_rises++;
    if (a_bus_rw) begin
      a_mem[a_bus_addr] <= a_bus_data;
      a_wr[a_bus_addr]  <= 1'b1;
    end
  end
  always @(negedge clk) if (a_rsp_valid) a_rsps++;

  // ---------------- instance B (CLK_DIV = 1) ----------------
  logic        b_req_valid, b_req_write, b_req_ready, b_rsp_valid, b_bus_rw, b_bus_clk;
  logic [15:0] b_req_addr, b_bus_addr;
  logic [7:0]  b_req_data, b_rsp_data;
  tri1  [7:0]  b_bus_data;

  bus_master #(.CLK_DIV(DB)) dut_b (
    .Clock(clk), .Reset(rst_n), .ReqValid(b_req_valid), .ReqReady(b_req_ready),
    .ReqWrite(b_req_write), .ReqAddress(b_req_addr), .ReqData(b_req_data),
    .RspValid(b_rsp_valid), .RspData(b_rsp_data), .BusAddress(b_bus_addr),
    .BusData(b_bus_data), .BusReadWrite(b_bus_rw), .BusClock(b_bus_clk)
  );

  bit [7:0] b_mem [65536];
  bit       b_wr  [65536];
  int       b_rises = 0;
  int       b_rsps  = 0;
  assign b_bus_data = b_bus_rw ? 8'bz : (b_wr[b_bus_addr] ? b_mem[b_bus_addr] : 8'hA5);
  always @(posedge b_bus_clk) begin
    b_rises++;
    if (b_bus_rw) begin
      b_mem[b_bus_addr] <= b_bus_data;
      b_wr[b_bus_addr]  <= 1'b1;
    end
  end
  always @(negedge clk) if (b_rsp_valid) b_rsps++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  task automatic wait_ready_a();
    for (int i = 0; i < 50 && !a_req_ready; i++) @(negedge clk);
    check("a_ready_wait", a_req_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_bclk"}, a_bus_clk, 0);   check({tag, "_b_bclk"}, b_bus_clk, 0);
    check({tag, "_a_rw"}, a_bus_rw, 1);      check({tag, "_b_rw"}, b_bus_rw, 1);
    check({tag, "_a_data"}, a_bus_data, 8'hFF); check({tag, "_b_data"}, b_bus_data, 8'hFF);
    check({tag, "_a_rsp"}, a_rsp_valid, 0);  check({tag, "_b_rsp"}, b_rsp_valid, 0);
    check({tag, "_a_rdy"}, a_req_ready, 0);  check({tag, "_a_addr"}, a_bus_addr, 0);
    check({tag, "_a_rdata"}, a_rsp_data, 0);
  endtask

  // One transaction on A, checked every cycle from the accept edge to completion.
  task automatic txn_a(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                       input logic [7:0] exp_rsp);
    int rises0;
    wait_ready_a();
    rises0 = a_rises;
    a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_data = data;
    for (int j = 0; j <= 3 * DA; j++) begin
      @(negedge clk);
      // Garbage presented while busy must be ignored.
      a_req_write = ~wr; a_req_addr = ~addr; a_req_data = ~data;
      check("bus_clk", a_bus_clk, (j >= DA && j < 2 * DA));
      check("rsp_valid", a_rsp_valid, (j == 3 * DA));
      check("req_ready", a_req_ready, (j == 3 * DA));
      check("bus_addr", a_bus_addr, addr);
      if (j < 3 * DA) begin
        check("bus_rw", a_bus_rw, wr);
        check("bus_data", a_bus_data, wr ? data : exp_rsp);
      end else begin
        check("bus_rw_idle", a_bus_rw, 1);
        check("bus_data_rel", a_bus_data, 8'hFF);
        check("rsp_data", a_rsp_data, exp_rsp);
        a_req_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("rsp_one_cycle", a_rsp_valid, 0);
    check("one_strobe", a_rises - rises0, 1);
    if (wr) check("slave_reg", a_mem[addr], data);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_rsp;
  } vec_t;
  vec_t tbl [8];

  // Reference model for B: transaction timing from accept time, memory as a map.
  logic [7:0] m_mem [logic [15:0]];
  function automatic logic [7:0] m_rd(input logic [15:0] a);
    return m_mem.exists(a) ? m_mem[a] : 8'hA5;
  endfunction

  initial begin
    int rises0, rsps0, acc, t, cyc;
    logic busy, mready, mwr, pv, pw, exp_rv;
    logic [15:0] maddr, pa;
    logic [7:0] mdata, mrsp, pd;

    tbl[0] = '{1'b1, 16'h0101, 8'h40, 8'h00};
    tbl[1] = '{1'b0, 16'h0101, 8'h00, 8'h40};
    tbl[2] = '{1'b0, 16'h0106, 8'h00, 8'hA5};
    tbl[3] = '{1'b1, 16'h0106, 8'h3C, 8'hA5};
    tbl[4] = '{1'b0, 16'h0106, 8'h00, 8'h3C};
    tbl[5] = '{1'b1, 16'hFFFF, 8'h00, 8'h3C};
    tbl[6] = '{1'b0, 16'hFFFF, 8'h00, 8'h00};
    tbl[7] = '{1'b0, 16'h0000, 8'h00, 8'hA5};

    // Reset held with random request activity.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_req_valid = 1'($urandom); a_req_write = 1'($urandom);
      a_req_addr = 16'($urandom); a_req_data = 8'($urandom);
      b_req_valid = 1'($urandom); b_req_write = 1'($urandom);
      b_req_addr = 16'($urandom); b_req_data = 8'($urandom);
      @(negedge clk);
      check_reset_outputs("rst");
    end
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 16'h0; a_req_data = 8'h0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 16'h0; b_req_data = 8'h0;
    rst_n = 1'b1;
    #1;
    check("rel_a_rdy0", a_req_ready, 0);
    @(negedge clk);
    check("rel_a_rdy1", a_req_ready, 1);
    check("rel_b_rdy1", b_req_ready, 1);

    for (int i = 0; i < 8; i++) txn_a(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp_rsp);

    // Back-to-back write then read with ReqValid held high.
    wait_ready_a();
    rises0 = a_rises;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 16'h0202; a_req_data = 8'h5A;
    for (int j = 0; j <= 6 * DA + 1; j++) begin
      int ph;
      logic second;
      @(negedge clk);
      second = (j > 3 * DA);
      ph = second ? j - (3 * DA + 1) : j;
      check("b2b_bclk", a_bus_clk, (ph >= DA && ph < 2 * DA));
      check("b2b_rsp", a_rsp_valid, (ph == 3 * DA));
      check("b2b_rdy", a_req_ready, (ph == 3 * DA));
      check("b2b_rw", a_bus_rw, (ph == 3 * DA) ? 1'b1 : !second);
      check("b2b_addr", a_bus_addr, 16'h0202);
      if (j == 3 * DA) a_req_write = 1'b0;
      if (j == 6 * DA + 1) begin
        check("b2b_rdata", a_rsp_data, 8'h5A);
        a_req_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_strobes", a_rises - rises0, 2);

    // Reset while BusClock is high abandons the read.
    wait_ready_a();
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 16'h0300;
    @(negedge clk);
    a_req_valid = 1'b0;
    repeat (DA) @(negedge clk);
    check("mid_strobe_hi", a_bus_clk, 1);
    rises0 = a_rises;
    rsps0 = a_rsps;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    #1;
    check("midrel_rdy0", a_req_ready, 0);
    @(negedge clk);
    check("midrel_rdy1", a_req_ready, 1);
    check("midrst_no_rsp", a_rsps - rsps0, 0);
    check("midrst_no_rise", a_rises - rises0, 0);
    txn_a(1'b1, 16'h0300, 8'h11, 8'h00);
    txn_a(1'b0, 16'h0300, 8'h00, 8'h11);

    // Randomized traffic on B against the model.
    busy = 1'b0; mready = b_req_ready; mwr = 1'b1; maddr = 16'h0; mdata = 8'h0;
    mrsp = 8'h0; acc = 0; t = 0;
    rises0 = b_rises; rsps0 = b_rsps;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (acc < 100) begin
        b_req_valid = ($urandom_range(0, 2) != 0);
        b_req_write = 1'($urandom);
        b_req_addr  = 16'($urandom_range(0, 15));
        b_req_data  = 8'($urandom);
      end else begin
        b_req_valid = 1'b0;
      end
      pv = b_req_valid; pw = b_req_write; pa = b_req_addr; pd = b_req_data;
      @(negedge clk);
      exp_rv = 1'b0;
      if (busy) begin
        t++;
        if (t == 3 * DB) begin
          busy = 1'b0;
          exp_rv = 1'b1;
          if (!mwr) mrsp = m_rd(maddr);
        end
      end else if (mready && pv) begin
        busy = 1'b1; t = 0; acc++;
        mwr = pw; maddr = pa; mdata = pd;
        if (pw) m_mem[pa] = pd;
      end
      mready = !busy;
      check("rnd_bclk", b_bus_clk, busy && t >= DB && t < 2 * DB);
      check("rnd_rsp", b_rsp_valid, exp_rv);
      check("rnd_rdy", b_req_ready, mready);
      check("rnd_rw", b_bus_rw, busy ? mwr : 1'b1);
      check("rnd_addr", b_bus_addr, maddr);
      check("rnd_rdata", b_rsp_data, mrsp);
      check("rnd_bdata", b_bus_data, busy ? (mwr ? mdata : m_rd(maddr)) : 8'hFF);
      if (acc >= 100 && !busy) break;
    end
    check("rnd_budget", (cyc < 3000), 1);
    @(negedge clk);
    check("rnd_strobes", b_rises - rises0, acc);
    check("rnd_rsps", b_rsps - rsps0, acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
